// File: rtl/hub75e_bcm_pkg.sv
// Shared types and helpers for the HUB75E binary-code-modulation scanner:
// the scan FSM states, the per-plane output-enable duration and the
// square-law gamma map used by the optional gamma stage.
package hub75e_bcm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  // OE-low cycles for a bit plane: each plane doubles the previous one.
  function automatic int unsigned oe_duration(input int unsigned lsb_cycles,
                                              input int unsigned plane);
    return lsb_cycles << plane;
  endfunction

  // Square-law brightness map with rounding: (v*v + M/2) / M, M = 2^w - 1.
  function automatic int unsigned gamma_map(input int unsigned value,
                                            input int unsigned w_color);
    int unsigned m;
    m = (32'd1 << w_color) - 32'd1;
    return (value * value + m / 2) / m;
  endfunction

endpackage

// File: rtl/hub75e_gamma_lut.sv
// Combinational square-law map for one colour channel. Used by the
// scanner only when HUB75E_BCM_SCANNER_GAMMA_EN is defined.
module hub75e_gamma_lut
  import hub75e_bcm_pkg::*;
#(
  parameter int w_color = 4
) (
  input  logic [w_color-1:0] value,
  output logic [w_color-1:0] mapped
);

  // Map the raw channel value onto the perceptual brightness curve
  always_comb begin
    mapped = w_color'(gamma_map(32'(value), w_color));
  end

endmodule

// File: rtl/hub75e_bcm_scanner.sv
// HUB75E panel scan engine with binary-code modulation.
// Requests pixels through x/y, captures one bit plane of the returned
// colour per pass, shifts two rows (r and r+H/2) into the panel, latches
// them and lights them for a plane-weighted OE time. Shift and display
// never overlap, and the row address only moves while the panel is dark.
// Optional feature: define HUB75E_BCM_SCANNER_GAMMA_EN to pass each
// captured channel through a square-law map before plane selection.
module hub75e_bcm_scanner
  import hub75e_bcm_pkg::*;
#(
  parameter int screen_width  = 64,
  parameter int screen_height = 64,
  parameter int w_color       = 4,
  parameter int pixel_latency = 1,
  parameter int clk_div       = 2,
  parameter int lsb_oe_cycles = 8,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  input  logic [w_color-1:0] red,
  input  logic [w_color-1:0] green,
  input  logic [w_color-1:0] blue,
  output logic               ck,
  output logic               st,
  output logic               oe,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               r1,
  output logic               g1,
  output logic               b1,
  output logic               r2,
  output logic               g2,
  output logic               b2,
  output logic               frame_start
);

  localparam int half_rows   = screen_height / 2;
  localparam int w_row       = (half_rows > 1) ? $clog2(half_rows) : 1;
  localparam int w_slot      = $clog2(screen_width + 1);
  localparam int slot_cycles = 2 * clk_div;
  localparam int w_cyc       = $clog2(slot_cycles);
  localparam int w_plane     = (w_color > 1) ? $clog2(w_color) : 1;
  localparam int oe_max      = int'(oe_duration(lsb_oe_cycles, w_color - 1));
  localparam int w_oe        = $clog2(oe_max + 1);

  localparam logic [w_slot-1:0]  last_slot    = w_slot'(screen_width);
  localparam logic [w_cyc-1:0]   last_cyc     = w_cyc'(slot_cycles - 1);
  localparam logic [w_cyc-1:0]   first_ck_cyc = w_cyc'(clk_div);
  localparam logic [w_cyc-1:0]   upper_cyc    = w_cyc'(pixel_latency);
  localparam logic [w_cyc-1:0]   lower_cyc    = w_cyc'(pixel_latency + 1);
  localparam logic [w_row-1:0]   last_row     = w_row'(half_rows - 1);
  localparam logic [w_plane-1:0] last_plane   = w_plane'(w_color - 1);
  // When the lower capture falls on the final slot cycle, the load at the
  // slot boundary must take the live bit instead of the stale capture.
  localparam bit lower_at_edge = (pixel_latency + 1 == slot_cycles - 1);

  scan_state_t        state, state_n;
  logic [w_slot-1:0]  slot, slot_n;
  logic [w_cyc-1:0]   cyc, cyc_n;
  logic [w_oe-1:0]    oe_cnt, oe_cnt_n, oe_last;
  logic [w_plane-1:0] plane, plane_n;
  logic [w_row-1:0]   row, row_n;
  logic               frame_start_n;
  logic               ck_n, request_n, load_data;

  logic [w_color-1:0] red_m, green_m, blue_m;
  logic               red_bit, green_bit, blue_bit;
  logic               cap_r1, cap_g1, cap_b1, cap_r2, cap_g2, cap_b2;

`ifdef HUB75E_BCM_SCANNER_GAMMA_EN
  hub75e_gamma_lut #(.w_color(w_color)) u_gamma_red   (.value(red),   .mapped(red_m));
  hub75e_gamma_lut #(.w_color(w_color)) u_gamma_green (.value(green), .mapped(green_m));
  hub75e_gamma_lut #(.w_color(w_color)) u_gamma_blue  (.value(blue),  .mapped(blue_m));
`else
  // Raw channel values feed plane selection directly
  always_comb begin
    red_m   = red;
    green_m = green;
    blue_m  = blue;
  end
`endif

  // Select the active bit plane from each (optionally mapped) channel
  always_comb begin
    red_bit   = red_m[plane];
    green_bit = green_m[plane];
    blue_bit  = blue_m[plane];
  end

  // Scan state and position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      slot   <= '0;
      cyc    <= '0;
      oe_cnt <= '0;
      plane  <= '0;
      row    <= '0;
    end else begin
      state  <= state_n;
      slot   <= slot_n;
      cyc    <= cyc_n;
      oe_cnt <= oe_cnt_n;
      plane  <= plane_n;
      row    <= row_n;
    end
  end

  // Next-state sequencing plus the look-ahead controls for registered outputs
  always_comb begin
    state_n       = state;
    slot_n        = slot;
    cyc_n         = cyc;
    oe_cnt_n      = oe_cnt;
    plane_n       = plane;
    row_n         = row;
    frame_start_n = 1'b0;
    oe_last       = w_oe'(oe_duration(lsb_oe_cycles, 32'(plane)) - 32'd1);
    case (state)
      IDLE: begin
        state_n       = SHIFT;
        slot_n        = '0;
        cyc_n         = '0;
        frame_start_n = 1'b1;
      end
      SHIFT: begin
        if (cyc == last_cyc) begin
          cyc_n = '0;
          if (slot == last_slot) begin
            slot_n  = '0;
            state_n = BLANK;
          end else begin
            slot_n = slot + 1'b1;
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      BLANK: state_n = LATCH;
      LATCH: begin
        state_n  = DISPLAY;
        oe_cnt_n = '0;
      end
      DISPLAY: begin
        if (oe_cnt == oe_last) begin
          state_n = SHIFT;
          slot_n  = '0;
          cyc_n   = '0;
          if (plane == last_plane) begin
            plane_n = '0;
            if (row == last_row) begin
              row_n         = '0;
              frame_start_n = 1'b1;
            end else begin
              row_n = row + 1'b1;
            end
          end else begin
            plane_n = plane + 1'b1;
          end
        end else begin
          oe_cnt_n = oe_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    request_n = (state_n == SHIFT) && (slot_n != last_slot);
    ck_n      = (state_n == SHIFT) && (slot_n != '0) && (cyc_n >= first_ck_cyc);
    load_data = (state == SHIFT) && (cyc == last_cyc) && (slot != last_slot);
  end

  // Sample the upper and lower pixel bits as they return from the source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cap_r1, cap_g1, cap_b1} <= 3'b000;
      {cap_r2, cap_g2, cap_b2} <= 3'b000;
    end else if (state == SHIFT && slot != last_slot) begin
      if (cyc == upper_cyc) {cap_r1, cap_g1, cap_b1} <= {red_bit, green_bit, blue_bit};
      if (cyc == lower_cyc) {cap_r2, cap_g2, cap_b2} <= {red_bit, green_bit, blue_bit};
    end
  end

  // Registered panel and pixel-request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      ck          <= 1'b0;
      st          <= 1'b0;
      oe          <= 1'b1;
      {e, d, c, b, a} <= 5'd0;
      {r1, g1, b1}    <= 3'b000;
      {r2, g2, b2}    <= 3'b000;
      frame_start <= 1'b0;
    end else begin
      ck          <= ck_n;
      st          <= (state_n == LATCH);
      oe          <= (state_n != DISPLAY);
      frame_start <= frame_start_n;
      if (request_n && cyc_n == '0) begin
        x <= slot_n[w_x-1:0];
        y <= w_y'(row_n);
      end else if (request_n && cyc_n == w_cyc'(1)) begin
        y <= w_y'(row_n) + w_y'(half_rows);
      end
      if (state_n == BLANK) begin
        {e, d, c, b, a} <= 5'(row);
      end
      if (load_data) begin
        {r1, g1, b1} <= {cap_r1, cap_g1, cap_b1};
        r2 <= lower_at_edge ? red_bit   : cap_r2;
        g2 <= lower_at_edge ? green_bit : cap_g2;
        b2 <= lower_at_edge ? blue_bit  : cap_b2;
      end
    end
  end

endmodule
